// File: rtl/seq_decoder_pkg.sv
// Shared types and the one-hot helper for seq_decoder.
package seq_decoder_pkg;

  localparam int MAX_OUT_W = 256;
  localparam int MAX_IN_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FULL = 2'd1,
    SCAN = 2'd2
  } state_e;

  // err sits in the LSB so a size cast to OUT_W+1 bits yields {vec[OUT_W-1:0], err}.
  typedef struct packed {
    logic [MAX_OUT_W-1:0] vec;
    logic                 err;
  } onehot_t;

  function automatic onehot_t onehot(input logic [MAX_IN_W-1:0] idx, input int out_w);
    onehot_t r;
    r.vec = '0;
    r.err = 1'b0;
    if (int'(idx) < out_w) begin
      r.vec[idx] = 1'b1;
    end else begin
      r.err = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_decoder_scan.sv
// Scan engine: walks an index across all channels with a programmable dwell gap
// after every accepted beat, then pulses done.
module seq_decoder_scan #(
  parameter int OUT_W   = 8,
  parameter int DWELL_W = 4,
  localparam int IN_W   = $clog2(OUT_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [IN_W-1:0]    idx_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               finish_o
);
  localparam logic [IN_W-1:0] LAST_IDX = IN_W'(OUT_W - 1);

  logic               busy_q, busy_d;
  logic               present_q, present_d;
  logic               done_q, done_d;
  logic [IN_W-1:0]    idx_q, idx_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic               finish;

  always_comb begin
    busy_d    = busy_q;
    present_d = present_q;
    done_d    = 1'b0;
    idx_d     = idx_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    finish    = 1'b0;
    if (start_i) begin
      busy_d    = 1'b1;
      present_d = 1'b1;
      idx_d     = '0;
      dwell_d   = dwell_i;
      cnt_d     = '0;
    end else if (busy_q) begin
      if (present_q) begin
        if (ready_i) begin
          if (dwell_q != '0) begin
            present_d = 1'b0;
            cnt_d     = dwell_q;
          end else if (idx_q == LAST_IDX) begin
            finish = 1'b1;
          end else begin
            idx_d = idx_q + IN_W'(1);
          end
        end
      end else begin
        // The dwell gap also follows the last beat, so done lands after it.
        cnt_d = cnt_q - DWELL_W'(1);
        if (cnt_q == DWELL_W'(1)) begin
          if (idx_q == LAST_IDX) begin
            finish = 1'b1;
          end else begin
            present_d = 1'b1;
            idx_d     = idx_q + IN_W'(1);
          end
        end
      end
      if (finish) begin
        busy_d    = 1'b0;
        present_d = 1'b0;
        done_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q    <= 1'b0;
      present_q <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      dwell_q   <= '0;
      cnt_q     <= '0;
    end else begin
      busy_q    <= busy_d;
      present_q <= present_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
    end
  end

  assign valid_o  = present_q;
  assign idx_o    = idx_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign finish_o = finish;

endmodule

// File: rtl/seq_decoder.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides.
// The scan engine is built only when DECODER_SCAN_EN is defined.
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int OUT_W   = 8,
  parameter int DWELL_W = 4,
  localparam int IN_W   = $clog2(OUT_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_err,
  input  logic               scan_start,
  input  logic [DWELL_W-1:0] scan_dwell,
  output logic               scan_busy,
  output logic               scan_done
);
  localparam int DEC_W = OUT_W + 1;

  state_e           state_q, state_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic [OUT_W-1:0] dec_vec;
  logic             dec_err;
  logic             accept;
  logic             pop;
  logic             scan_go;
  logic             scan_valid;
  logic             scan_finish;
  logic [OUT_W-1:0] scan_vec;

  assign {dec_vec, dec_err} = DEC_W'(onehot(MAX_IN_W'(in_data), OUT_W));

`ifdef DECODER_SCAN_EN
  logic [IN_W-1:0] scan_idx;
  logic [OUT_W-1:0] scan_dec;
  logic             scan_unused_err;

  assign scan_go = (state_q == IDLE) && scan_start;

  seq_decoder_scan #(
    .OUT_W  (OUT_W),
    .DWELL_W(DWELL_W)
  ) u_scan (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (scan_go),
    .dwell_i (scan_dwell),
    .ready_i (out_ready),
    .valid_o (scan_valid),
    .idx_o   (scan_idx),
    .busy_o  (scan_busy),
    .done_o  (scan_done),
    .finish_o(scan_finish)
  );

  assign {scan_dec, scan_unused_err} = DEC_W'(onehot(MAX_IN_W'(scan_idx), OUT_W));
  assign scan_vec = scan_valid ? scan_dec : '0;
`else
  logic unused_scan_inputs;

  assign unused_scan_inputs = ^{scan_start, scan_dwell};
  assign scan_go     = 1'b0;
  assign scan_valid  = 1'b0;
  assign scan_finish = 1'b0;
  assign scan_vec    = '0;
  assign scan_busy   = 1'b0;
  assign scan_done   = 1'b0;
`endif

  assign out_valid = (state_q == FULL) || ((state_q == SCAN) && scan_valid);
  assign in_ready  = rst_n && (state_q != SCAN) && (!out_valid || out_ready);
  // A scan request in IDLE wins over a simultaneous index beat.
  assign accept    = in_valid && in_ready && !scan_go;
  assign pop       = (state_q == FULL) && out_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (scan_go) begin
          state_d = SCAN;
        end else if (accept) begin
          state_d = FULL;
          data_d  = dec_vec;
          err_d   = dec_err;
        end
      end
      FULL: begin
        if (accept) begin
          data_d = dec_vec;
          err_d  = dec_err;
        end else if (pop) begin
          state_d = IDLE;
          data_d  = '0;
          err_d   = 1'b0;
        end
      end
      SCAN: begin
        if (scan_finish) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Direct-mode registers stay cleared while the scan engine owns the output.
  assign out_data = (state_q == SCAN) ? scan_vec : data_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Directed bench for seq_decoder: three instances (OUT_W = 8, 6, 4) sharing clock and reset.
module tb_seq_decoder;

  logic clk;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
  logic [2:0] a_in_data;
  logic [7:0] a_out_data;
  logic       a_scan_start, a_scan_busy, a_scan_done;
  logic [3:0] a_scan_dwell;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
  logic [2:0] b_in_data;
  logic [5:0] b_out_data;
  logic       b_scan_start, b_scan_busy, b_scan_done;
  logic [3:0] b_scan_dwell;

  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
  logic [1:0] c_in_data;
  logic [3:0] c_out_data;
  logic       c_scan_start, c_scan_busy, c_scan_done;
  logic [3:0] c_scan_dwell;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [3:0] scan_data_exp [13] = '{4'h1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0,
                                     4'h8, 4'h0, 4'h0, 4'h0};
  logic       scan_valid_exp [13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                      1'b1, 1'b0, 1'b0, 1'b0};

  seq_decoder #(.OUT_W(8), .DWELL_W(4)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err),
    .scan_start(a_scan_start), .scan_dwell(a_scan_dwell), .scan_busy(a_scan_busy), .scan_done(a_scan_done)
  );

  seq_decoder #(.OUT_W(6), .DWELL_W(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err),
    .scan_start(b_scan_start), .scan_dwell(b_scan_dwell), .scan_busy(b_scan_busy), .scan_done(b_scan_done)
  );

  seq_decoder #(.OUT_W(4), .DWELL_W(4)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_err(c_out_err),
    .scan_start(c_scan_start), .scan_dwell(c_scan_dwell), .scan_busy(c_scan_busy), .scan_done(c_scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 1; a_scan_start = 0; a_scan_dwell = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 1; b_scan_start = 0; b_scan_dwell = 0;
    c_in_valid = 0; c_in_data = 0; c_out_ready = 1; c_scan_start = 0; c_scan_dwell = 0;

    // Reset state
    tick();
    tick();
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_a_out_err", a_out_err, 0);
    chk("rst_a_scan_busy", a_scan_busy, 0);
    chk("rst_a_scan_done", a_scan_done, 0);
    chk("rst_b_in_ready", b_in_ready, 0);
    chk("rst_b_scan_busy", b_scan_busy, 0);
    chk("rst_c_in_ready", c_in_ready, 0);
    chk("rst_c_scan_busy", c_scan_busy, 0);
    chk("rst_c_scan_done", c_scan_done, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_a_in_ready", a_in_ready, 1);

    // Back-to-back sweep 0..7 on OUT_W=8
    a_in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      a_in_data = 3'(i);
      #1;
      chk($sformatf("sweep_in_ready_%0d", i), a_in_ready, 1);
      tick();
      chk($sformatf("sweep_valid_%0d", i), a_out_valid, 1);
      chk($sformatf("sweep_data_%0d", i), a_out_data, sweep_exp[i]);
      chk($sformatf("sweep_err_%0d", i), a_out_err, 0);
    end
    a_in_valid = 0;
    tick();
    chk("sweep_pop_valid", a_out_valid, 0);
    chk("sweep_pop_data", a_out_data, 0);

    // Out-of-range on OUT_W=6
    b_in_valid = 1;
    b_in_data = 3'd6;
    tick();
    chk("oor6_valid", b_out_valid, 1);
    chk("oor6_data", b_out_data, 0);
    chk("oor6_err", b_out_err, 1);
    b_in_data = 3'd7;
    tick();
    chk("oor7_valid", b_out_valid, 1);
    chk("oor7_data", b_out_data, 0);
    chk("oor7_err", b_out_err, 1);
    b_in_data = 3'd5;
    tick();
    chk("b5_data", b_out_data, 6'h20);
    chk("b5_err", b_out_err, 0);
    b_in_valid = 0;
    b_in_data = 3'd7;
    tick();
    chk("b_pop_valid", b_out_valid, 0);
    chk("b_pop_err", b_out_err, 0);

    // Stall on OUT_W=8: beat 3 held while a competing index waits
    a_in_valid = 1;
    a_in_data = 3'd3;
    tick();
    chk("stall_first", a_out_data, 8'h08);
    a_in_data = 3'd6;
    for (int i = 0; i < 5; i++) begin
      a_out_ready = 0;
      #1;
      chk($sformatf("stall_in_ready_%0d", i), a_in_ready, 0);
      tick();
      chk($sformatf("stall_valid_%0d", i), a_out_valid, 1);
      chk($sformatf("stall_data_%0d", i), a_out_data, 8'h08);
    end
    a_out_ready = 1;
    a_in_data = 3'd5;
    #1;
    chk("unstall_in_ready", a_in_ready, 1);
    tick();
    chk("unstall_data", a_out_data, 8'h20);
    chk("unstall_valid", a_out_valid, 1);
    a_in_valid = 0;
    tick();
    chk("unstall_pop", a_out_valid, 0);

`ifdef DECODER_SCAN_EN
    // Scan OUT_W=4, dwell=2; index 1 is offered alongside scan_start and after
    c_scan_start = 1;
    c_scan_dwell = 4'd2;
    c_in_valid = 1;
    c_in_data = 2'd1;
    tick();
    c_scan_start = 0;
    c_scan_dwell = 4'd9;
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("scan_valid_%0d", k), c_out_valid, scan_valid_exp[k]);
      chk($sformatf("scan_data_%0d", k), c_out_data, scan_data_exp[k]);
      chk($sformatf("scan_err_%0d", k), c_out_err, 0);
      chk($sformatf("scan_busy_%0d", k), c_scan_busy, (k < 12) ? 1 : 0);
      chk($sformatf("scan_done_%0d", k), c_scan_done, (k == 12) ? 1 : 0);
      chk($sformatf("scan_in_ready_%0d", k), c_in_ready, (k < 12) ? 0 : 1);
      tick();
    end
    chk("post_scan_done", c_scan_done, 0);
    chk("post_scan_valid", c_out_valid, 1);
    chk("post_scan_data", c_out_data, 4'h2);
    c_in_valid = 0;
    tick();
    chk("post_scan_pop", c_out_valid, 0);

    // Mid-scan reset during beat idx=2 (dwell=1)
    c_scan_start = 1;
    c_scan_dwell = 4'd1;
    tick();
    c_scan_start = 0;
    tick();
    tick();
    tick();
    tick();
    chk("mid_beat2_valid", c_out_valid, 1);
    chk("mid_beat2_data", c_out_data, 4'h4);
    rst_n = 0;
    tick();
    chk("mid_rst_valid", c_out_valid, 0);
    chk("mid_rst_data", c_out_data, 0);
    chk("mid_rst_busy", c_scan_busy, 0);
    chk("mid_rst_done", c_scan_done, 0);
    chk("mid_rst_in_ready", c_in_ready, 0);
    rst_n = 1;
    tick();
    chk("mid_after_done", c_scan_done, 0);
    chk("mid_after_busy", c_scan_busy, 0);
    c_scan_start = 1;
    c_scan_dwell = 4'd0;
    tick();
    c_scan_start = 0;
    chk("restart_beat0", c_out_data, 4'h1);
    chk("restart_busy", c_scan_busy, 1);
    tick();
    chk("restart_beat1", c_out_data, 4'h2);
    tick();
    chk("restart_beat2", c_out_data, 4'h4);
    tick();
    chk("restart_beat3", c_out_data, 4'h8);
    tick();
    chk("restart_done", c_scan_done, 1);
    chk("restart_busy_end", c_scan_busy, 0);
    chk("restart_valid_end", c_out_valid, 0);
    tick();
    chk("restart_done_pulse", c_scan_done, 0);
`else
    // Scan disabled: scan_start ignored, decoding unaffected
    c_scan_start = 1;
    c_scan_dwell = 4'd2;
    c_in_valid = 1;
    c_in_data = 2'd2;
    tick();
    c_scan_start = 0;
    chk("noscan_busy", c_scan_busy, 0);
    chk("noscan_done", c_scan_done, 0);
    chk("noscan_valid", c_out_valid, 1);
    chk("noscan_data", c_out_data, 4'h4);
    c_in_data = 2'd3;
    tick();
    chk("noscan_data3", c_out_data, 4'h8);
    c_in_valid = 0;
    tick();
    chk("noscan_pop", c_out_valid, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("noscan_busy_%0d", k), c_scan_busy, 0);
      chk($sformatf("noscan_done_%0d", k), c_scan_done, 0);
      tick();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
